// File: rtl/regfile_pkg.sv
// Shared definitions for register-file write-port logic.
//   REG_ADDR_W / DATA_W / NUM_REGS : register-file geometry
//   arb_state_t                    : write-port arbiter state
//   wr_req_t                       : one write request (destination + value)
//   pending_mask()                 : one-hot pending bit for a destination,
//                                    empty for the hardwired-zero register
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE1 = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wr_req_t;

    function automatic logic [NUM_REGS-1:0] pending_mask(input logic [REG_ADDR_W-1:0] addr);
        pending_mask = '0;
        if (addr != '0) begin
            pending_mask[addr] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating starvation counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one more lost cycle this edge
//   clr        : restart from zero this edge (wins over inc)
//   terminal   : combinational; high when this edge brings the count to LIMIT
module starve_counter #(
    parameter int LIMIT = 4,
    parameter int W     = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic terminal
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] count;

    // NOTE: state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIM)) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = inc && !clr && (count == LIM - 1'b1);

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback
// (requester 0, fixed priority) and the multi-cycle unit (requester 1). A
// starvation counter forces one grant to requester 1 after STARVE_LIMIT lost
// cycles.
//   clk, reset                  : clock, asynchronous active-low reset
//   req{0,1}_valid/_reg/_data   : write requests (valid/ready handshake)
//   req{0,1}_ready              : combinational accept indications
//   RegWrite/WriteRegister/
//   WriteData                   : registered regfile write port
//   wr_pending                  : registered, one bit per register with an
//                                 accepted write not yet captured by the regfile
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [REG_ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0]     req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [REG_ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0]     req1_data,
    output logic                  req1_ready,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0]     WriteData,
    output logic [NUM_REGS-1:0]   wr_pending
);

    arb_state_t state, state_next;
    logic       acc0, acc1, starve_hit;
    wr_req_t    sel;

    // Readys depend only on the state register and req0_valid, so they
    // never both allow a transfer in the same cycle.
    assign req0_ready = (state == NORMAL);
    assign req1_ready = (state == FORCE1) || !req0_valid;

    assign acc0 = req0_valid && req0_ready;
    assign acc1 = req1_valid && req1_ready;

    assign sel = acc0 ? '{addr: req0_reg, data: req0_data}
                      : '{addr: req1_reg, data: req1_data};

    starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (CNT_W)
    ) u_starve (
        .clk      (clk),
        .rst_n    (reset),
        .inc      (req1_valid && !acc1),
        .clr      (!req1_valid || acc1),
        .terminal (starve_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= NORMAL;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaulting state_next before the case keeps this block latch-free.
    always_comb begin
        state_next = state;
        unique case (state)
            NORMAL: if (starve_hit) state_next = FORCE1;
            FORCE1: if (acc1)       state_next = NORMAL;
            default:                state_next = NORMAL;
        endcase
    end

    // Register 0 writes are accepted but never reach the regfile. Address
    // and data hold across idle cycles; only the enable and pending drop.
    // NOTE: only control/state flops need reset; the data path is reset here
    // as well because the regfile port must come up all-zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            wr_pending    <= '0;
        end else if (acc0 || acc1) begin
            RegWrite      <= (sel.addr != '0);
            WriteRegister <= sel.addr;
            WriteData     <= sel.data;
            wr_pending    <= pending_mask(sel.addr);
        end else begin
            RegWrite      <= 1'b0;
            wr_pending    <= '0;
        end
    end

endmodule
